// File: rtl/row_scan_controller.sv
// LED matrix row scanner: walks row_sel over N_ROWS rows, each row gets BLANK_CLKS blank then ON_CLKS driven.
// All outputs registered (one edge from ena to any output); no backpressure, ena=0 aborts to IDLE on the next edge.
module row_scan_controller #(
   parameter int N_ROWS     = 8,
   parameter int ON_CLKS    = 1000,
   parameter int BLANK_CLKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   output logic [2:0] row_sel,
   output logic       row_ena,
   output logic       row_start,
   output logic       frame_done,
   output logic       busy
);

   localparam int MAX_CLKS = (ON_CLKS > BLANK_CLKS) ? ON_CLKS : BLANK_CLKS;
   localparam int CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;

   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CLKS - 1);
   localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CLKS - 1);
   localparam logic [2:0]       LAST_ROW   = 3'(N_ROWS - 1);

   generate
      if (N_ROWS < 1 || N_ROWS > 8 || ON_CLKS < 1 || BLANK_CLKS < 1) begin : g_bad_params
         $error("row_scan_controller: illegal parameters N_ROWS=%0d ON_CLKS=%0d BLANK_CLKS=%0d",
                N_ROWS, ON_CLKS, BLANK_CLKS);
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       row_sel_q, row_sel_d;
   logic             row_ena_q, row_ena_d;
   logic             row_start_q, row_start_d;
   logic             frame_done_q, frame_done_d;
   logic             busy_q, busy_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         row_sel_q    <= '0;
         row_ena_q    <= 1'b0;
         row_start_q  <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_sel_q    <= row_sel_d;
         row_ena_q    <= row_ena_d;
         row_start_q  <= row_start_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      row_sel_d    = row_sel_q;
      row_ena_d    = row_ena_q;
      row_start_d  = 1'b0;
      frame_done_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d     = '0;
            row_sel_d = '0;
            row_ena_d = 1'b0;
            if (ena) begin
               state_d     = ST_BLANK;
               cnt_d       = BLANK_LOAD;
               row_start_d = 1'b1;
            end
         end
         ST_BLANK: begin
            row_ena_d = 1'b0;
            if (cnt_q == '0) begin
               state_d   = ST_DRIVE;
               row_ena_d = 1'b1;
               cnt_d     = ON_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DRIVE: begin
            row_ena_d = 1'b1;
            if (cnt_q == '0) begin
               // Select only moves on the edge that drops row_ena, so the decoder never glitches while lit.
               state_d     = ST_BLANK;
               row_ena_d   = 1'b0;
               row_start_d = 1'b1;
               cnt_d       = BLANK_LOAD;
               if (row_sel_q == LAST_ROW) begin
                  row_sel_d    = '0;
                  frame_done_d = 1'b1;
               end else begin
                  row_sel_d = row_sel_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Stop request overrides everything, including a row boundary on the same edge.
      if (state_q != ST_IDLE && !ena) begin
         state_d      = ST_IDLE;
         cnt_d        = '0;
         row_sel_d    = '0;
         row_ena_d    = 1'b0;
         row_start_d  = 1'b0;
         frame_done_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign row_sel    = row_sel_q;
   assign row_ena    = row_ena_q;
   assign row_start  = row_start_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_row_scan_controller.sv
// Bench for row_scan_controller: three instances (8, 5, 1 rows) share one stimulus; a row-period model feeds a scoreboard.
module tb_row_scan_controller;

   localparam int ON    = 4;
   localparam int BLANK = 2;
   localparam int P     = ON + BLANK;

   logic clk = 1'b0;
   logic rst_n;
   logic ena;

   logic [2:0] sel8, sel5, sel1;
   logic       re8, re5, re1;
   logic       rs8, rs5, rs1;
   logic       fd8, fd5, fd1;
   logic       bz8, bz5, bz1;

   always #5 clk = ~clk;

   row_scan_controller #(.N_ROWS(8), .ON_CLKS(ON), .BLANK_CLKS(BLANK)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .row_sel(sel8), .row_ena(re8),
      .row_start(rs8), .frame_done(fd8), .busy(bz8));
   row_scan_controller #(.N_ROWS(5), .ON_CLKS(ON), .BLANK_CLKS(BLANK)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .row_sel(sel5), .row_ena(re5),
      .row_start(rs5), .frame_done(fd5), .busy(bz5));
   row_scan_controller #(.N_ROWS(1), .ON_CLKS(ON), .BLANK_CLKS(BLANK)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .row_sel(sel1), .row_ena(re1),
      .row_start(rs1), .frame_done(fd1), .busy(bz1));

   // {busy, frame_done, row_start, row_ena, row_sel}
   logic [6:0] obs [3];
   assign obs[0] = {bz8, fd8, rs8, re8, sel8};
   assign obs[1] = {bz5, fd5, rs5, re5, sel5};
   assign obs[2] = {bz1, fd1, rs1, re1, sel1};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int n_of  [3] = '{8, 5, 1};
   int m_run [3];
   int m_phase [3];
   int m_row [3];
   int m_fd  [3];

   logic [20:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Reference: position within the row period decides every output.
   function automatic logic [6:0] model_out(input int d);
      logic [6:0] o;
      logic [2:0] r;
      o = '0;
      if (m_run[d] != 0) begin
         r = 3'(m_row[d]);
         o = {1'b1, (m_fd[d] != 0 && m_phase[d] == 0), (m_phase[d] == 0), (m_phase[d] >= BLANK), r};
      end
      return o;
   endfunction

   task automatic model_edge(input int d, input logic e);
      if (m_run[d] == 0) begin
         if (e) begin
            m_run[d] = 1; m_phase[d] = 0; m_row[d] = 0; m_fd[d] = 0;
         end
      end else if (!e) begin
         m_run[d] = 0; m_phase[d] = 0; m_row[d] = 0; m_fd[d] = 0;
      end else begin
         m_phase[d] = m_phase[d] + 1;
         m_fd[d] = 0;
         if (m_phase[d] == P) begin
            m_phase[d] = 0;
            m_row[d] = m_row[d] + 1;
            if (m_row[d] == n_of[d]) begin
               m_row[d] = 0;
               m_fd[d] = 1;
            end
         end
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_run[d] = 0; m_phase[d] = 0; m_row[d] = 0; m_fd[d] = 0;
      end
   endtask

   // Drive ena for one edge, push the expected post-edge outputs, then compare.
   task automatic step(input logic e);
      logic [20:0] ex;
      ena = e;
      for (int d = 0; d < 3; d++) begin
         model_edge(d, e);
         ex[7*d +: 7] = model_out(d);
      end
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      cyc++;
      ex = exp_q.pop_front();
      for (int d = 0; d < 3; d++)
         check($sformatf("n%0d_cyc%0d", n_of[d], cyc), 32'(obs[d]), 32'(ex[7*d +: 7]));
   endtask

   initial begin
      int start_cyc;
      rst_n = 1'b0;
      ena   = 1'b0;
      model_reset();
      #12;
      for (int d = 0; d < 3; d++)
         check($sformatf("reset_n%0d", n_of[d]), 32'(obs[d]), 32'd0);
      #5 rst_n = 1'b1;

      // Idle with ena low
      for (int i = 0; i < 20; i++) step(1'b0);

      // Start and run one full frame of the 8-row instance
      step(1'b1);
      check("first_row_start", 32'(rs8), 32'd1);
      start_cyc = cyc;
      for (int i = 0; i < 100; i++) begin
         step(1'b1);
         if (fd8) break;
      end
      check("frame_period", 32'(cyc - start_cyc), 32'd48);
      check("fd_row_sel", 32'(sel8), 32'd0);
      check("fd_row_start", 32'(rs8), 32'd1);

      // Drop ena during the 2nd DRIVE cycle of row 3
      for (int i = 0; i < 100; i++) begin
         if (sel8 == 3'd3 && re8) break;
         step(1'b1);
      end
      step(1'b1);
      check("row3_drive", 32'({sel8, re8}), 32'({3'd3, 1'b1}));
      step(1'b0);
      check("stop_busy", 32'({bz8, re8, sel8}), 32'd0);
      step(1'b0);
      step(1'b1);
      for (int i = 0; i < 14; i++) step(1'b1);

      // Single-cycle ena glitch from IDLE
      step(1'b0);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      step(1'b0);

      // Asynchronous reset in the middle of DRIVE
      step(1'b1);
      for (int i = 0; i < 20; i++) begin
         if (re8) break;
         step(1'b1);
      end
      step(1'b1);
      check("pre_reset_row_ena", 32'(re8), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async_row_ena8", 32'(re8), 32'd0);
      check("async_row_ena5", 32'(re5), 32'd0);
      check("async_busy1", 32'(bz1), 32'd0);
      model_reset();
      #2 rst_n = 1'b1;
      step(1'b1);
      check("restart_row_start", 32'({rs8, sel8}), 32'({1'b1, 3'd0}));
      for (int i = 0; i < 12; i++) step(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
